cp0_timer_intc: RTL and testbench

CP0_TIMER_INTC -- requirements
Module: cp0_timer_intc

---
 rtl/cp0_timer_intc_pkg.sv | 27 ++
 rtl/cp0_cmp_chan.sv | 41 ++++
 rtl/cp0_timer_intc.sv | 137 +++++++++++++
 tb/tb_cp0_timer_intc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_timer_intc_pkg.sv
// Shared CP0 definitions for the timer/interrupt block: CP0 register
// numbers, Status register field positions, and a small address-decode helper.
package cp0_timer_intc_pkg;

  localparam int CP0_DATA_W = 32;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;

  // Status register fields
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;

  // Software interrupt bits live at Cause[9:8] in the write data
  localparam int CAUSE_SW_LO = 8;
  localparam int CAUSE_SW_HI = 9;

  function automatic logic reg_hit(input logic [4:0] addr, input logic [2:0] sel,
                                   input logic [4:0] reg_num, input logic [2:0] reg_sel);
    return (addr == reg_num) && (sel == reg_sel);
  endfunction

endpackage

// File: rtl/cp0_cmp_chan.sv
// One Compare channel: holds the Compare register and its sticky pending flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   we            write strobe for this channel's Compare register
//   data          write data
//   count         current (pre-increment) Count value
//   compare       Compare register value
//   pending       timer pending flag; set on match, cleared only by a Compare write
module cp0_cmp_chan
  import cp0_timer_intc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [CP0_DATA_W-1:0] data,
  input  logic [CP0_DATA_W-1:0] count,
  output logic [CP0_DATA_W-1:0] compare,
  output logic                  pending
);

  logic [CP0_DATA_W-1:0] cmp_q;
  logic                  pend_q;

  // A write in the match cycle takes priority so the flag stays clear.
  // Compare == 0 is treated as disabled and never matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q  <= '0;
      pend_q <= 1'b0;
    end else if (we) begin
      cmp_q  <= data;
      pend_q <= 1'b0;
    end else if ((cmp_q != '0) && (count == cmp_q)) begin
      pend_q <= 1'b1;
    end
  end

  assign compare = cmp_q;
  assign pending = pend_q;

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with Cause IP collection and interrupt request.
// Build option: define CP0_INT_SYNC_EN for a 2-flop synchroniser on ext_int_i
// (2 cycles to ip_o); otherwise the lines are registered once (1 cycle).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   we_i/waddr_i/wsel_i/data_i  CP0 write port
//   raddr_i/rsel_i/data_o    CP0 read port (combinational)
//   ext_int_i                level-sensitive external interrupt lines
//   status_i                 Status register (IM, EXL, IE)
//   count_o                  Count register
//   ip_o                     Cause IP[7:0]
//   timer_int_o              per-channel timer pending flags
//   int_req_o                registered interrupt request
module cp0_timer_intc
  import cp0_timer_intc_pkg::*;
#(
  parameter int N_CMP    = 2,
  parameter int N_EXT    = 6,
  parameter int TIMER_IP = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [2:0]       wsel_i,
  input  logic [31:0]      data_i,
  input  logic [4:0]       raddr_i,
  input  logic [2:0]       rsel_i,
  output logic [31:0]      data_o,
  input  logic [N_EXT-1:0] ext_int_i,
  input  logic [31:0]      status_i,
  output logic [31:0]      count_o,
  output logic [7:0]       ip_o,
  output logic [N_CMP-1:0] timer_int_o,
  output logic             int_req_o
);

  logic [31:0]      count_q;
  logic [31:0]      cmp_val [N_CMP];
  logic [1:0]       sw_ip_q;
  logic [N_EXT-1:0] ext_sync;
  logic [7:0]       ip;
  logic             int_req_q;
  logic             count_we;
  logic             cause_we;

  // Status bits outside IM/EXL/IE are not used here.
  logic unused_status;
  assign unused_status = ^{status_i[31:16], status_i[7:2]};

  assign count_we = we_i && reg_hit(waddr_i, wsel_i, CP0_REG_COUNT, 3'd0);
  assign cause_we = we_i && reg_hit(waddr_i, wsel_i, CP0_REG_CAUSE, 3'd0);

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else if (count_we)
      count_q <= data_i;
    else
      count_q <= count_q + 32'd1;
  end

  // Channels see the pre-increment Count; writes with wsel >= N_CMP hit nothing.
  for (genvar k = 0; k < N_CMP; k++) begin : g_cmp
    cp0_cmp_chan u_chan (
      .clk     (clk),
      .rst     (rst),
      .we      (we_i && reg_hit(waddr_i, wsel_i, CP0_REG_COMPARE, 3'(k))),
      .data    (data_i),
      .count   (count_q),
      .compare (cmp_val[k]),
      .pending (timer_int_o[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      sw_ip_q <= 2'b00;
    else if (cause_we)
      sw_ip_q <= data_i[CAUSE_SW_HI:CAUSE_SW_LO];
  end

`ifdef CP0_INT_SYNC_EN
  logic [N_EXT-1:0] ext_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_meta <= '0;
      ext_sync <= '0;
    end else begin
      ext_meta <= ext_int_i;
      ext_sync <= ext_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      ext_sync <= '0;
    else
      ext_sync <= ext_int_i;
  end
`endif

  // Timer pending is merged onto its IP bit on top of whatever else maps there.
  always_comb begin
    ip               = '0;
    ip[1:0]          = sw_ip_q;
    ip[N_EXT+1:2]    = ext_sync;
    ip[TIMER_IP]     = ip[TIMER_IP] | (|timer_int_o);
  end

  always_ff @(posedge clk) begin
    if (rst)
      int_req_q <= 1'b0;
    else
      int_req_q <= status_i[STATUS_IE] & ~status_i[STATUS_EXL]
                   & (|(ip & status_i[STATUS_IM_HI:STATUS_IM_LO]));
  end

  // Reads see register state before any same-cycle write lands.
  always_comb begin
    data_o = '0;
    if (reg_hit(raddr_i, rsel_i, CP0_REG_COUNT, 3'd0))
      data_o = count_q;
    if (reg_hit(raddr_i, rsel_i, CP0_REG_CAUSE, 3'd0))
      data_o = {16'b0, ip, 8'b0};
    for (int k = 0; k < N_CMP; k++) begin
      if (reg_hit(raddr_i, rsel_i, CP0_REG_COMPARE, 3'(k)))
        data_o = cmp_val[k];
    end
  end

  assign count_o   = count_q;
  assign ip_o      = ip;
  assign int_req_o = int_req_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc with a cycle-level reference model.
module tb_cp0_timer_intc;

  localparam int N_CMP    = 2;
  localparam int N_EXT    = 6;
  localparam int TIMER_IP = 7;
`ifdef CP0_INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             we_i = 1'b0;
  logic [4:0]       waddr_i = '0;
  logic [2:0]       wsel_i = '0;
  logic [31:0]      data_i = '0;
  logic [4:0]       raddr_i = '0;
  logic [2:0]       rsel_i = '0;
  logic [31:0]      data_o;
  logic [N_EXT-1:0] ext_int_i = '0;
  logic [31:0]      status_i = '0;
  logic [31:0]      count_o;
  logic [7:0]       ip_o;
  logic [N_CMP-1:0] timer_int_o;
  logic             int_req_o;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_timer_intc #(.N_CMP(N_CMP), .N_EXT(N_EXT), .TIMER_IP(TIMER_IP)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i),
    .data_i(data_i), .raddr_i(raddr_i), .rsel_i(rsel_i), .data_o(data_o),
    .ext_int_i(ext_int_i), .status_i(status_i), .count_o(count_o), .ip_o(ip_o),
    .timer_int_o(timer_int_o), .int_req_o(int_req_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Count is kept as "value loaded at edge number cnt_cyc" plus elapsed edges.
  longint           cyc = 0;
  longint           cnt_cyc = 0;
  logic [31:0]      cnt_base = '0;
  logic [31:0]      m_cmp [N_CMP];
  logic             m_pend [N_CMP];
  logic [1:0]       m_sw = '0;
  logic             m_req = 1'b0;
  logic [N_EXT-1:0] ext_hist [$];
  bit               m_valid = 1'b0;

  function automatic logic [31:0] m_count();
    return cnt_base + 32'(cyc - cnt_cyc);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0] v;
    logic [N_EXT-1:0] e;
    logic any_t;
    v = '0;
    v[1:0] = m_sw;
    e = (ext_hist.size() >= LAT) ? ext_hist[LAT-1] : '0;
    for (int i = 0; i < N_EXT; i++) v[i+2] = e[i];
    any_t = 1'b0;
    for (int k = 0; k < N_CMP; k++) any_t |= m_pend[k];
    if (any_t) v[TIMER_IP] = 1'b1;
    return v;
  endfunction

  function automatic logic [N_CMP-1:0] m_tint();
    logic [N_CMP-1:0] t;
    for (int k = 0; k < N_CMP; k++) t[k] = m_pend[k];
    return t;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (a == 5'd9 && s == 3'd0) return m_count();
    if (a == 5'd13 && s == 3'd0) return {16'b0, m_ip(), 8'b0};
    if (a == 5'd11 && int'(s) < N_CMP) return m_cmp[s];
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] pre_cnt;
    logic [7:0]  pre_ip;
    pre_cnt = m_count();
    pre_ip  = m_ip();
    cyc++;
    if (rst) begin
      cnt_base = '0;
      cnt_cyc  = cyc;
      for (int k = 0; k < N_CMP; k++) begin
        m_cmp[k]  = '0;
        m_pend[k] = 1'b0;
      end
      m_sw  = '0;
      m_req = 1'b0;
      ext_hist.delete();
      m_valid = 1'b1;
    end else begin
      for (int k = 0; k < N_CMP; k++) begin
        if (we_i && waddr_i == 5'd11 && int'(wsel_i) == k) begin
          m_cmp[k]  = data_i;
          m_pend[k] = 1'b0;
        end else if (m_cmp[k] != 0 && pre_cnt == m_cmp[k]) begin
          m_pend[k] = 1'b1;
        end
      end
      if (we_i && waddr_i == 5'd9 && wsel_i == 3'd0) begin
        cnt_base = data_i;
        cnt_cyc  = cyc;
      end
      if (we_i && waddr_i == 5'd13 && wsel_i == 3'd0) m_sw = data_i[9:8];
      m_req = status_i[0] && !status_i[1] && ((pre_ip & status_i[15:8]) != 8'h00);
      ext_hist.push_front(ext_int_i);
      if (ext_hist.size() > 4) void'(ext_hist.pop_back());
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model count_o", count_o, m_count());
      chk("model ip_o", 32'(ip_o), 32'(m_ip()));
      chk("model timer_int_o", 32'(timer_int_o), 32'(m_tint()));
      chk("model int_req_o", 32'(int_req_o), 32'(m_req));
      chk("model data_o", data_o, m_read(raddr_i, rsel_i));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wsel_i = s; data_i = d;
    tick();
    we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [2:0] s,
                        input logic [31:0] exp);
    raddr_i = a; rsel_i = s;
    #1;
    chk(name, data_o, exp);
  endtask

  initial begin
    // Reset
    tick();
    rst = 1'b0;
    chk("reset count", count_o, 32'd0);
    chk("reset ip", 32'(ip_o), 32'd0);
    chk("reset timer_int", 32'(timer_int_o), 32'd0);
    chk("reset int_req", 32'(int_req_o), 32'd0);

    // Compare[0] = 20 written at Count 10
    status_i = 32'h0000_8001;
    repeat (10) tick();
    chk("count at 10", count_o, 32'd10);
    wr(5'd11, 3'd0, 32'd20);
    repeat (9) tick();
    chk("count at 20", count_o, 32'd20);
    chk("no match yet", 32'(timer_int_o), 32'd0);
    tick();
    chk("timer0 set", 32'(timer_int_o), 32'b01);
    chk("ip7 set", 32'(ip_o[7]), 32'd1);
    chk("int_req lag", 32'(int_req_o), 32'd0);
    tick();
    chk("int_req set", 32'(int_req_o), 32'd1);

    // Out-of-range select ignored
    wr(5'd11, 3'd2, 32'd5);
    rd_chk("cmp0 intact", 5'd11, 3'd0, 32'd20);
    rd_chk("cmp1 intact", 5'd11, 3'd1, 32'd0);
    rd_chk("cmp2 reads 0", 5'd11, 3'd2, 32'd0);

    // Wrap and match on Compare[1] = 1
    wr(5'd11, 3'd0, 32'd0);
    wr(5'd11, 3'd1, 32'd1);
    wr(5'd9, 3'd0, 32'hFFFF_FFFE);
    chk("count loaded", count_o, 32'hFFFF_FFFE);
    tick();
    chk("count ffffffff", count_o, 32'hFFFF_FFFF);
    tick();
    chk("count wrapped", count_o, 32'd0);
    tick();
    chk("count 1", count_o, 32'd1);
    chk("pre match1", 32'(timer_int_o), 32'd0);
    tick();
    chk("timer1 set", 32'(timer_int_o), 32'b10);

    // Write in the exact match cycle wins
    wr(5'd9, 3'd0, 32'd100);
    wr(5'd11, 3'd0, 32'd105);
    repeat (4) tick();
    chk("count 105", count_o, 32'd105);
    wr(5'd11, 3'd0, 32'd105);
    chk("write beats match", 32'(timer_int_o), 32'b10);
    repeat (3) tick();
    chk("still clear", 32'(timer_int_o), 32'b10);

    // Compare = 0 never matches across a wrap
    wr(5'd11, 3'd0, 32'd0);
    wr(5'd9, 3'd0, 32'hFFFF_FFF0);
    repeat (20) tick();
    chk("count past wrap", count_o, 32'd4);
    chk("zero cmp silent", 32'(timer_int_o), 32'b10);

    // Read during write returns old value
    wr(5'd9, 3'd0, 32'h0000_1000);
    we_i = 1'b1; waddr_i = 5'd9; wsel_i = 3'd0; data_i = 32'h55;
    raddr_i = 5'd9; rsel_i = 3'd0;
    #1;
    chk("read old count", data_o, 32'h0000_1000);
    tick();
    we_i = 1'b0; data_i = '0;
    chk("count written", count_o, 32'h55);

    // External interrupt path
    status_i  = 32'h0000_0401;
    ext_int_i = 6'b000001;
    repeat (LAT) tick();
    chk("ip2 after sync", 32'(ip_o[2]), 32'd1);
    chk("int_req not yet", 32'(int_req_o), 32'd0);
    tick();
    chk("int_req ext", 32'(int_req_o), 32'd1);
    status_i = 32'h0000_0403;
    tick();
    chk("exl masks", 32'(int_req_o), 32'd0);

    // Software interrupts through Cause
    ext_int_i = '0;
    status_i  = '0;
    wr(5'd11, 3'd1, 32'd0);
    repeat (LAT) tick();
    wr(5'd13, 3'd0, 32'h300);
    chk("sw ip", 32'(ip_o), 32'h03);
    rd_chk("cause read", 5'd13, 3'd0, 32'h0000_0300);
    rd_chk("unmapped read", 5'd12, 3'd0, 32'd0);

    // Reset while both channels pending
    wr(5'd9, 3'd0, 32'h1200);
    wr(5'd11, 3'd0, 32'h1210);
    wr(5'd11, 3'd1, 32'h1211);
    repeat (32'h32) tick();
    chk("count 1234", count_o, 32'h1234);
    chk("both pending", 32'(timer_int_o), 32'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst count", count_o, 32'd0);
    chk("rst timer", 32'(timer_int_o), 32'd0);
    chk("rst ip", 32'(ip_o), 32'd0);
    chk("rst int_req", 32'(int_req_o), 32'd0);
    rd_chk("rst cmp0", 5'd11, 3'd0, 32'd0);
    rd_chk("rst cmp1", 5'd11, 3'd1, 32'd0);
    repeat (5) tick();
    chk("post rst count", count_o, 32'd5);
    chk("post rst no match", 32'(timer_int_o), 32'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
